// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants and types for the drum-sample memory.
//                Both the recorder and the playback counters take their
//                address range from here.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 18;

    // Last writable RAM address; capacity is MAXCOUNT+1 samples.
    localparam logic [ADDR_W-1:0] MAXCOUNT = 18'd229120;

    // Onset threshold on the unsigned sample magnitude.
    localparam logic [DATA_W-1:0] THRESH = 16'd2048;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] sample_t;

    // Recorder state encoding.
    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_REC   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sample_recorder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_recorder_if
//  Description : Control, codec-sample and RAM-write signals of the sample
//                recorder. The master side issues arm/stop and codec
//                samples; the slave side is the recorder itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface sample_recorder_if;
    import audio_pkg::*;

    // Control and codec input
    logic    arm;
    logic    stop;
    logic    in_valid;
    sample_t in_data;

    // RAM write port and status
    logic    wr_en;
    addr_t   wr_addr;
    sample_t wr_data;
    addr_t   length;
    logic    busy;
    logic    done;

    modport master (
        output arm, stop, in_valid, in_data,
        input  wr_en, wr_addr, wr_data, length, busy, done
    );

    modport slave (
        input  arm, stop, in_valid, in_data,
        output wr_en, wr_addr, wr_data, length, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/abs_sat.sv
`default_nettype none
// ============================================================================
//  Module      : abs_sat
//  Description : Saturating absolute value. W-bit two's complement in,
//                (W-1)-bit unsigned magnitude out; the most negative input
//                saturates to the largest positive magnitude.
//  Revision    : 1.0  initial release
// ============================================================================
module abs_sat #(
    parameter int W = 16
) (
    input  wire logic signed [W-1:0] din,
    output logic             [W-2:0] mag
);

    logic [W-1:0] w_neg;

    // Negate negative inputs; only the most negative value cannot be
    // represented in W-1 bits, so it is clamped to all ones.
    always_comb begin
        w_neg = -din;
        if (!din[W-1]) begin
            mag = din[W-2:0];
        end else if (din[W-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = w_neg[W-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : sample_recorder
//  Description : Writer side of the drum-sample memory. After arm, waits for
//                a codec sample whose magnitude reaches the onset threshold,
//                then writes every valid sample to sequential RAM addresses
//                0..LAST_ADDR until stop or the memory is full.
//  Revision    : 1.0  initial release
// ============================================================================
module sample_recorder
    import audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST_ADDR    = audio_pkg::MAXCOUNT,
    parameter logic [DATA_W-1:0] ONSET_THRESH = audio_pkg::THRESH
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sample_recorder_if.slave bus
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    // Next address to write, which is also the count of samples written.
    addr_t   r_addr;
    addr_t   r_length;
    addr_t   w_count_nxt;

    logic    r_wr_en;
    addr_t   r_wr_addr;
    sample_t r_wr_data;
    logic    r_done;

    logic [DATA_W-2:0] w_mag;
    logic              w_onset;
    logic              w_take;
    logic              w_last;
    logic              w_rearm;

    abs_sat #(
        .W (DATA_W)
    ) u_abs_sat (
        .din (bus.in_data),
        .mag (w_mag)
    );

    assign w_onset = bus.in_valid && ({1'b0, w_mag} >= ONSET_THRESH);

    // arm is only honoured while idle or in the single DONE cycle.
    assign w_rearm = bus.arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next state and sample acceptance. In ARMED a stop cancels the wait
    // even if an onset sample arrives in the same cycle, since recording
    // has not yet begun. In REC a sample arriving with stop is still kept.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = bus.arm ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_onset) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_REC;
                end
            end
            ST_REC: begin
                w_take = bus.in_valid;
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Writing the last address ends the take; the address never wraps.
        w_last = w_take && (r_addr == LAST_ADDR);
        if (w_last) begin
            w_state_nxt = ST_DONE;
        end
    end

    assign w_count_nxt = r_addr + {{(ADDR_W-1){1'b0}}, w_take};

    // FSM, address counter, captured length and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_length <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_rearm) begin
                r_addr   <= '0;
                r_length <= '0;
            end else begin
                r_addr <= w_count_nxt;
                if (w_state_nxt == ST_DONE) begin
                    r_length <= w_count_nxt;
                end
            end
        end
    end

    // Registered RAM write port: one strobe per accepted sample, one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_take;
            if (w_take) begin
                r_wr_addr <= r_addr;
                r_wr_data <= bus.in_data;
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.length  = r_length;
    assign bus.done    = r_done;
    assign bus.busy    = (r_state == ST_ARMED) || (r_state == ST_REC);

endmodule
`default_nettype wire

// File: tb/tb_sample_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_recorder
//  Description : Self-checking bench for sample_recorder: directed vector
//                table, multi-cycle corner sequences and random stimulus
//                against a behavioural capture model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sample_recorder;
    import audio_pkg::*;

    // Reduced capacity keeps the full-memory case short.
    localparam int TB_MAX    = 600;
    localparam int TB_THRESH = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_recorder_if bus ();

    sample_recorder #(
        .LAST_ADDR    (ADDR_W'(TB_MAX)),
        .ONSET_THRESH (DATA_W'(TB_THRESH))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: waiting for onset / recording flags plus a list
    // length; expected outputs for the cycle after each edge.
    bit          m_wait, m_rec;
    int          m_cnt;
    bit          e_we, e_done;
    int          e_addr, e_len;
    logic [15:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int magnitude(input logic [15:0] d);
        int x;
        x = int'($signed(d));
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    task automatic capture(input logic [15:0] d);
        e_we   = 1'b1;
        e_addr = m_cnt;
        e_data = d;
        m_cnt++;
    endtask

    task automatic model_step(input bit r, input bit a, input bit s, input bit v, input logic [15:0] d);
        e_we   = 1'b0;
        e_done = 1'b0;
        if (r) begin
            m_wait = 0; m_rec = 0; m_cnt = 0; e_len = 0;
        end else if (m_wait) begin
            if (s) begin
                m_wait = 0;
            end else if (v && magnitude(d) >= TB_THRESH) begin
                capture(d);
                m_wait = 0;
                m_rec  = 1;
                if (m_cnt == TB_MAX + 1) begin
                    m_rec = 0; e_len = m_cnt; e_done = 1;
                end
            end
        end else if (m_rec) begin
            if (v) capture(d);
            if (s || m_cnt == TB_MAX + 1) begin
                m_rec = 0; e_len = m_cnt; e_done = 1;
            end
        end else if (a) begin
            m_wait = 1; m_cnt = 0; e_len = 0;
        end
    endtask

    // One clock: drive inputs, advance the model, sample outputs #1 after the edge.
    task automatic step(input bit r, input bit a, input bit s, input bit v, input logic [15:0] d);
        reset        = r;
        bus.arm      = a;
        bus.stop     = s;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        model_step(r, a, s, v, d);
        #1;
        check("wr_en", {31'd0, bus.wr_en}, {31'd0, e_we});
        if (e_we) begin
            check("wr_addr", {14'd0, bus.wr_addr}, e_addr);
            check("wr_data", {16'd0, bus.wr_data}, {16'd0, e_data});
        end
        check("done", {31'd0, bus.done}, {31'd0, e_done});
        check("busy", {31'd0, bus.busy}, {31'd0, (m_wait | m_rec)});
        check("length", {14'd0, bus.length}, e_len);
    endtask

    typedef struct {
        bit a, s, v;
        int d;
        bit we;
        int addr;
        int data;
        bit done, busy;
        int len;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit a, input bit s, input bit v, input int d,
                                input bit we, input int addr, input int data,
                                input bit done, input bit busy, input int len);
        vec_t t;
        t.a = a; t.s = s; t.v = v; t.d = d;
        t.we = we; t.addr = addr; t.data = data;
        t.done = done; t.busy = busy; t.len = len;
        return t;
    endfunction

    initial begin
        int last_addr;
        bit seen_done;
        int extra_we;
        logic [15:0] rd;

        reset = 1'b1; bus.arm = 0; bus.stop = 0; bus.in_valid = 0; bus.in_data = '0;
        m_wait = 0; m_rec = 0; m_cnt = 0; e_len = 0; e_we = 0; e_done = 0; e_addr = 0; e_data = '0;

        // Reset state
        step(1, 0, 0, 0, 16'd0);
        step(1, 0, 0, 0, 16'd0);
        check("rst_wr_addr", {14'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);

        // Directed table: a, s, v, d | we, addr, data, done, busy, length
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 100,    0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, -50,    0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3000,   1, 0, 3000,   0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 5,      1, 1, 5,      0, 1, 0));
        tbl.push_back(mk(0, 1, 1, -7,     1, 2, -7,     1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8000,   1, 0, 8000,   0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 10,     1, 1, 10,     0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2047,   0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, -2047,  0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, -2048,  1, 0, -2048,  0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2048,   1, 0, 2048,   0, 1, 0));
        tbl.push_back(mk(0, 0, 1, -32768, 1, 1, -32768, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 1, 0));
        tbl.push_back(mk(0, 0, 1, -32768, 1, 0, -32768, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0, 0,      1, 0, 1));

        foreach (tbl[i]) begin
            step(0, tbl[i].a, tbl[i].s, tbl[i].v, 16'(tbl[i].d));
            check($sformatf("tbl%0d_we", i), {31'd0, bus.wr_en}, {31'd0, tbl[i].we});
            if (tbl[i].we) begin
                check($sformatf("tbl%0d_addr", i), {14'd0, bus.wr_addr}, tbl[i].addr);
                check($sformatf("tbl%0d_data", i), {16'd0, bus.wr_data}, {16'd0, 16'(tbl[i].data)});
            end
            check($sformatf("tbl%0d_done", i), {31'd0, bus.done}, {31'd0, tbl[i].done});
            check($sformatf("tbl%0d_busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
            check($sformatf("tbl%0d_len", i), {14'd0, bus.length}, tbl[i].len);
        end

        // Onset plus nine samples, stop together with the tenth
        step(0, 0, 0, 0, 16'd0);
        step(0, 1, 0, 0, 16'd0);
        step(0, 0, 0, 1, 16'd4000);
        check("seq10_addr0", {14'd0, bus.wr_addr}, 32'd0);
        for (int i = 1; i < 10; i++) begin
            step(0, 0, (i == 9), 1, 16'(i * 3));
            check("seq10_addr", {14'd0, bus.wr_addr}, i);
        end
        check("seq10_len", {14'd0, bus.length}, 32'd10);
        check("seq10_done", {31'd0, bus.done}, 32'd1);
        step(0, 0, 0, 0, 16'd0);
        check("seq10_done_width", {31'd0, bus.done}, 32'd0);

        // Continuous samples until the memory is full
        step(0, 1, 0, 0, 16'd0);
        step(0, 0, 0, 1, 16'h7000);
        last_addr = 0;
        seen_done = 0;
        for (int k = 0; k < TB_MAX + 20 && !seen_done; k++) begin
            step(0, 0, 0, 1, 16'($urandom));
            if (bus.wr_en) last_addr = int'(bus.wr_addr);
            if (bus.done) seen_done = 1;
        end
        check("full_done_seen", {31'd0, seen_done}, 32'd1);
        check("full_last_addr", last_addr, TB_MAX);
        check("full_len", {14'd0, bus.length}, TB_MAX + 1);
        extra_we = 0;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 16'h7000);
            if (bus.wr_en) extra_we++;
        end
        check("full_no_wrap", extra_we, 32'd0);

        // Reset in the middle of a take, right after address 500 is written
        step(0, 1, 0, 0, 16'd0);
        step(0, 0, 0, 1, 16'h9000);
        for (int k = 1; k <= 500; k++) step(0, 0, 0, 1, 16'(k));
        check("rst_mid_addr", {14'd0, bus.wr_addr}, 32'd500);
        step(1, 0, 0, 1, 16'd123);
        check("rst_mid_we", {31'd0, bus.wr_en}, 32'd0);
        check("rst_mid_len", {14'd0, bus.length}, 32'd0);
        step(0, 0, 0, 1, 16'd5000);
        check("rst_mid_idle", {31'd0, bus.wr_en | bus.busy}, 32'd0);

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0:       rd = 16'(int'($urandom_range(0, 4095)) - 2048);
                1:       rd = 16'($urandom);
                2:       rd = 16'h8000;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       rd = 16'd2047;
                        1:       rd = 16'd2048;
                        2:       rd = 16'(-2047);
                        default: rd = 16'(-2048);
                    endcase
                end
            endcase
            step(($urandom_range(0, 999) < 3),
                 ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 60),
                 rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
